// File: rtl/vnu3_ib_load_dp.sv
// VNU3 IB-map load datapath: fetch IB ROM rows and write them into bank0/bank1.
// Define VNU3_LOAD_OUT_REG_EN to add one output register stage on the write port.
// A fetch on the last row wraps rom_addr to 0; overrun flags a fetch after that wrap.
module vnu3_ib_load_dp #(
   parameter int unsigned LOAD_CYCLE = 64,
   parameter int unsigned DATA_WIDTH = 4,
   parameter int unsigned ITER_MAX   = 15,
   localparam int unsigned AW = $clog2(LOAD_CYCLE),
   localparam int unsigned IW = $clog2(ITER_MAX + 1)
) (
   input  logic                    write_clk,
   input  logic                    rstn,
   input  logic                    rom_port_fetch,
   input  logic                    ram_mux_en,
   input  logic                    ram_write_en,
   input  logic                    iter_update,
   input  logic                    v3ib_rom_rst,
   input  logic                    iter_clr,
   input  logic [2*DATA_WIDTH-1:0] rom_data,
   output logic [AW-1:0]           rom_addr,
   output logic [AW-1:0]           ram_wr_addr,
   output logic [DATA_WIDTH-1:0]   bank0_wr_data,
   output logic [DATA_WIDTH-1:0]   bank1_wr_data,
   output logic                    ram_we,
   output logic [IW-1:0]           iter_cnt,
   output logic                    load_done,
   output logic                    overrun
);

   localparam logic [AW-1:0] LAST_ROW = AW'(LOAD_CYCLE - 1);
   localparam logic [IW-1:0] ITER_SAT = IW'(ITER_MAX);

   logic [AW-1:0]         r_rom_addr;
   logic                  r_wrapped;
   logic                  r_overrun;
   logic [AW-1:0]         r_addr_d1;
   logic                  r_vld_d1;
   logic [AW-1:0]         r_addr_d2;
   logic [DATA_WIDTH-1:0] r_d0_d2;
   logic [DATA_WIDTH-1:0] r_d1_d2;
   logic                  r_vld_d2;
   logic [AW-1:0]         r_addr_d3;
   logic [DATA_WIDTH-1:0] r_d0_d3;
   logic [DATA_WIDTH-1:0] r_d1_d3;
   logic                  r_we_d3;
   logic [AW-1:0]         r_row_cnt;
   logic                  r_load_done;
   logic                  r_iter_upd_d;
   logic [IW-1:0]         r_iter_cnt;
   logic                  w_cap_d2;
   logic                  w_we_d3;
   logic                  w_iter_fall;

   assign w_cap_d2    = ram_mux_en & r_vld_d1 & ~v3ib_rom_rst;
   assign w_we_d3     = r_vld_d2 & ram_write_en & ~v3ib_rom_rst;
   assign w_iter_fall = r_iter_upd_d & ~iter_update;

   // ROM row address counter with wrap tracking for the overrun flag
   always_ff @(posedge write_clk or negedge rstn) begin
      if (!rstn) begin
         r_rom_addr <= '0;
         r_wrapped  <= 1'b0;
         r_overrun  <= 1'b0;
      end else if (v3ib_rom_rst) begin
         r_rom_addr <= '0;
         r_wrapped  <= 1'b0;
      end else if (rom_port_fetch) begin
         if (r_wrapped) begin
            r_overrun <= 1'b1;
         end
         if (r_rom_addr == LAST_ROW) begin
            r_rom_addr <= '0;
            r_wrapped  <= 1'b1;
         end else begin
            r_rom_addr <= r_rom_addr + AW'(1);
         end
      end
   end

   // Stage 1: remember which row was addressed while the ROM read is in flight
   always_ff @(posedge write_clk or negedge rstn) begin
      if (!rstn) begin
         r_addr_d1 <= '0;
         r_vld_d1  <= 1'b0;
      end else begin
         r_vld_d1 <= rom_port_fetch & ~v3ib_rom_rst;
         if (rom_port_fetch) begin
            r_addr_d1 <= r_rom_addr;
         end
      end
   end

   // Stage 2: capture ROM data halves alongside their row address
   always_ff @(posedge write_clk or negedge rstn) begin
      if (!rstn) begin
         r_addr_d2 <= '0;
         r_d0_d2   <= '0;
         r_d1_d2   <= '0;
         r_vld_d2  <= 1'b0;
      end else begin
         r_vld_d2 <= w_cap_d2;
         if (w_cap_d2) begin
            r_addr_d2 <= r_addr_d1;
            r_d0_d2   <= rom_data[DATA_WIDTH-1:0];
            r_d1_d2   <= rom_data[2*DATA_WIDTH-1:DATA_WIDTH];
         end
      end
   end

   // Stage 3: write strobe, with address/data kept aligned to it
   always_ff @(posedge write_clk or negedge rstn) begin
      if (!rstn) begin
         r_addr_d3 <= '0;
         r_d0_d3   <= '0;
         r_d1_d3   <= '0;
         r_we_d3   <= 1'b0;
      end else begin
         r_we_d3 <= w_we_d3;
         if (w_we_d3) begin
            r_addr_d3 <= r_addr_d2;
            r_d0_d3   <= r_d0_d2;
            r_d1_d3   <= r_d1_d2;
         end
      end
   end

`ifdef VNU3_LOAD_OUT_REG_EN
   logic [AW-1:0]         r_addr_o;
   logic [DATA_WIDTH-1:0] r_d0_o;
   logic [DATA_WIDTH-1:0] r_d1_o;
   logic                  r_we_o;

   // Extra output stage; a row already in stage 3 still completes on abort
   always_ff @(posedge write_clk or negedge rstn) begin
      if (!rstn) begin
         r_addr_o <= '0;
         r_d0_o   <= '0;
         r_d1_o   <= '0;
         r_we_o   <= 1'b0;
      end else begin
         r_addr_o <= r_addr_d3;
         r_d0_o   <= r_d0_d3;
         r_d1_o   <= r_d1_d3;
         r_we_o   <= r_we_d3;
      end
   end

   assign ram_wr_addr   = r_addr_o;
   assign bank0_wr_data = r_d0_o;
   assign bank1_wr_data = r_d1_o;
   assign ram_we        = r_we_o;
`else
   assign ram_wr_addr   = r_addr_d3;
   assign bank0_wr_data = r_d0_d3;
   assign bank1_wr_data = r_d1_d3;
   assign ram_we        = r_we_d3;
`endif

   // Written-row counter; load_done follows the write of the last row
   always_ff @(posedge write_clk or negedge rstn) begin
      if (!rstn) begin
         r_row_cnt   <= '0;
         r_load_done <= 1'b0;
      end else begin
         r_load_done <= ~v3ib_rom_rst & ram_we & (r_row_cnt == LAST_ROW);
         if (v3ib_rom_rst) begin
            r_row_cnt <= '0;
         end else if (ram_we) begin
            r_row_cnt <= (r_row_cnt == LAST_ROW) ? '0 : r_row_cnt + AW'(1);
         end
      end
   end

   // Iteration counter: counts falling edges of iter_update, saturating
   always_ff @(posedge write_clk or negedge rstn) begin
      if (!rstn) begin
         r_iter_upd_d <= 1'b0;
         r_iter_cnt   <= '0;
      end else begin
         r_iter_upd_d <= iter_update;
         if (iter_clr) begin
            r_iter_cnt <= '0;
         end else if (w_iter_fall && (r_iter_cnt != ITER_SAT)) begin
            r_iter_cnt <= r_iter_cnt + IW'(1);
         end
      end
   end

   assign rom_addr  = r_rom_addr;
   assign overrun   = r_overrun;
   assign load_done = r_load_done;
   assign iter_cnt  = r_iter_cnt;

endmodule

// File: tb/tb_vnu3_ib_load_dp.sv
// Scoreboard bench for vnu3_ib_load_dp: expected writes queued at fetch time, checked by a monitor.
module tb_vnu3_ib_load_dp;

   localparam int unsigned LC = 64;
   localparam int unsigned DW = 4;
   localparam int unsigned IM = 15;
   localparam int unsigned AW = 6;
   localparam int unsigned IW = 4;
`ifdef VNU3_LOAD_OUT_REG_EN
   localparam int unsigned LAT = 4;
`else
   localparam int unsigned LAT = 3;
`endif

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] d0;
      logic [DW-1:0] d1;
      logic [31:0]   cyc;
   } wr_t;

   logic          write_clk = 1'b0;
   logic          rstn = 1'b1;
   logic          rom_port_fetch = 1'b0;
   logic          ram_mux_en = 1'b0;
   logic          ram_write_en = 1'b0;
   logic          iter_update = 1'b0;
   logic          v3ib_rom_rst = 1'b0;
   logic          iter_clr = 1'b0;
   logic [2*DW-1:0] rom_data = '0;
   logic [AW-1:0] rom_addr;
   logic [AW-1:0] ram_wr_addr;
   logic [DW-1:0] bank0_wr_data;
   logic [DW-1:0] bank1_wr_data;
   logic          ram_we;
   logic [IW-1:0] iter_cnt;
   logic          load_done;
   logic          overrun;

   int          errors = 0;
   int          checks = 0;
   int          done_cnt = 0;
   int          done_base = 0;
   logic        prev_last = 1'b0;
   logic [31:0] cyc = '0;
   wr_t         exp_q[$];

   vnu3_ib_load_dp #(.LOAD_CYCLE(LC), .DATA_WIDTH(DW), .ITER_MAX(IM)) dut (
      .write_clk     (write_clk),
      .rstn          (rstn),
      .rom_port_fetch(rom_port_fetch),
      .ram_mux_en    (ram_mux_en),
      .ram_write_en  (ram_write_en),
      .iter_update   (iter_update),
      .v3ib_rom_rst  (v3ib_rom_rst),
      .iter_clr      (iter_clr),
      .rom_data      (rom_data),
      .rom_addr      (rom_addr),
      .ram_wr_addr   (ram_wr_addr),
      .bank0_wr_data (bank0_wr_data),
      .bank1_wr_data (bank1_wr_data),
      .ram_we        (ram_we),
      .iter_cnt      (iter_cnt),
      .load_done     (load_done),
      .overrun       (overrun)
   );

   always #5 write_clk = ~write_clk;

   function automatic logic [DW-1:0] pat_lo(input logic [AW-1:0] a);
      return a[DW-1:0];
   endfunction

   function automatic logic [DW-1:0] pat_hi(input logic [AW-1:0] a);
      return DW'(a >> 2) ^ 4'h5;
   endfunction

   // Synchronous IB ROM: data for an address appears one cycle later
   always @(posedge write_clk) begin
      rom_data <= {pat_hi(rom_addr), pat_lo(rom_addr)};
      cyc      <= cyc + 32'd1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge write_clk);
      #1;
   endtask

   task automatic rom_rst_pulse();
      v3ib_rom_rst = 1'b1;
      tick();
      v3ib_rom_rst = 1'b0;
   endtask

   // Fetch n_fetch rows from 0; the first n_push are expected to be written
   task automatic load(input int n_fetch, input int n_push, input logic en);
      ram_mux_en   = en;
      ram_write_en = en;
      for (int i = 0; i < n_fetch; i++) begin
         rom_port_fetch = 1'b1;
         if (i < n_push) begin
            exp_q.push_back('{addr: AW'(i), d0: pat_lo(AW'(i)), d1: pat_hi(AW'(i)),
                              cyc: cyc + 32'(LAT)});
         end
         tick();
      end
      rom_port_fetch = 1'b0;
   endtask

   task automatic drain();
      repeat (6) tick();
      ram_mux_en   = 1'b0;
      ram_write_en = 1'b0;
      tick();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
      check({tag, "_wr_addr"}, 32'(ram_wr_addr), 32'd0);
      check({tag, "_bank0"}, 32'(bank0_wr_data), 32'd0);
      check({tag, "_bank1"}, 32'(bank1_wr_data), 32'd0);
      check({tag, "_ram_we"}, 32'(ram_we), 32'd0);
      check({tag, "_iter_cnt"}, 32'(iter_cnt), 32'd0);
      check({tag, "_load_done"}, 32'(load_done), 32'd0);
      check({tag, "_overrun"}, 32'(overrun), 32'd0);
   endtask

   task automatic check_full_load(input string tag);
      done_base = done_cnt;
      load(64, 64, 1'b1);
      drain();
      check({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
      check({tag, "_done_count"}, 32'(done_cnt - done_base), 32'd1);
      check({tag, "_overrun"}, 32'(overrun), 32'd0);
      check({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
   endtask

   initial begin
      fork
         // Monitor: compare every presented write and load_done against expectations
         forever begin
            wr_t e;
            @(negedge write_clk);
            if (load_done) begin
               done_cnt++;
               check("load_done_follows_last_row", 32'(prev_last), 32'd1);
            end
            if (ram_we) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_write: addr %0d written, none expected", ram_wr_addr);
               end else begin
                  e = exp_q.pop_front();
                  check("wr_addr", 32'(ram_wr_addr), 32'(e.addr));
                  check("bank0_data", 32'(bank0_wr_data), 32'(e.d0));
                  check("bank1_data", 32'(bank1_wr_data), 32'(e.d1));
                  check("write_cycle", cyc, e.cyc);
               end
            end
            prev_last = ram_we && (ram_wr_addr == AW'(LC - 1));
         end
      join_none

      #1 rstn = 1'b0;
      #1 check_all_zero("reset");
      tick();
      tick();
      rstn = 1'b1;
      tick();

      // Full 64-row load
      rom_rst_pulse();
      check_full_load("load1");

      // Overrun after wrap: 64 fetches wrap cleanly, the 65th flags
      rom_rst_pulse();
      load(64, 0, 1'b0);
      check("wrap_rom_addr", 32'(rom_addr), 32'd0);
      check("wrap_no_overrun", 32'(overrun), 32'd0);
      load(1, 0, 1'b0);
      check("overrun_set", 32'(overrun), 32'd1);
      check("overrun_rom_addr", 32'(rom_addr), 32'd1);
      rom_rst_pulse();
      check("overrun_sticky", 32'(overrun), 32'd1);
      check("rom_rst_addr", 32'(rom_addr), 32'd0);

      // Iteration counter saturation and clear
      for (int i = 0; i < 20; i++) begin
         iter_update = 1'b1;
         tick();
         iter_update = 1'b0;
         tick();
         if (i == 4) check("iter_cnt_5", 32'(iter_cnt), 32'd5);
      end
      check("iter_cnt_sat", 32'(iter_cnt), 32'(IM));
      iter_update = 1'b1;
      tick();
      iter_update = 1'b0;
      iter_clr = 1'b1;
      tick();
      iter_clr = 1'b0;
      check("iter_clr_over_inc", 32'(iter_cnt), 32'd0);
      iter_update = 1'b1;
      tick();
      iter_update = 1'b0;
      tick();
      check("iter_cnt_after_clr", 32'(iter_cnt), 32'd1);

      // Abort after 10 written rows
      rom_rst_pulse();
      done_base = done_cnt;
      ram_mux_en   = 1'b1;
      ram_write_en = 1'b1;
      for (int i = 0; i <= 12; i++) begin
         rom_port_fetch = 1'b1;
         v3ib_rom_rst   = (i == 12);
         if (i < 10) begin
            exp_q.push_back('{addr: AW'(i), d0: pat_lo(AW'(i)), d1: pat_hi(AW'(i)),
                              cyc: cyc + 32'(LAT)});
         end
         tick();
      end
      rom_port_fetch = 1'b0;
      v3ib_rom_rst   = 1'b0;
      drain();
      check("abort_ram_we", 32'(ram_we), 32'd0);
      check("abort_rom_addr", 32'(rom_addr), 32'd0);
      check("abort_pending_writes", 32'(exp_q.size()), 32'd0);
      check("abort_no_done", 32'(done_cnt - done_base), 32'd0);

      // Asynchronous reset mid-load, then a clean reload
      rom_rst_pulse();
      load(20, 20 - int'(LAT), 1'b1);
      rstn = 1'b0;
      #1 check_all_zero("async_rst");
      ram_mux_en   = 1'b0;
      ram_write_en = 1'b0;
      tick();
      tick();
      rstn = 1'b1;
      check("async_rst_pending_writes", 32'(exp_q.size()), 32'd0);
      tick();
      check_full_load("reload");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
